// File: rtl/dm_arbiter.sv
// ============================================================================
// dm_arbiter
// ----------------------------------------------------------------------------
// Shares the single-port byte-enabled data memory between the CPU MEM-stage
// port (port 0) and a word-only DMA/bridge port (port 1). The winning request
// is latched, one memory access is issued with byte enables and
// lane-replicated write data, and a one-cycle acknowledge is returned
// carrying the read word.
//
// Sequence per access: gnt (cycle N, IDLE or RESP) -> mem_en (N+1, ACCESS)
// -> ack + rdata (N+2, RESP). A new grant may issue in the RESP cycle, so
// back-to-back traffic gets one access every two cycles.
//
// Configuration macro:
//   DM_ARB_RR_EN  defined   : ties alternate using a last-winner pointer
//                             (pointer resets to DMA, so the CPU wins the
//                             first tie).
//                 undefined : CPU has fixed priority on ties.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   cpu_req    in   CPU request, held until cpu_gnt
//   cpu_we     in   CPU write (1) / read (0)
//   cpu_type   in   2  store type: 1 word, 2 byte, 3 half, 0 illegal
//   cpu_addr   in   ADDR_W CPU byte address
//   cpu_wdata  in   32 CPU write data, right-aligned
//   cpu_gnt    out  grant pulse (combinational in IDLE/RESP)
//   cpu_ack    out  completion pulse
//   dma_*      same as CPU port, always word-sized
//   rdata      out  32 read word for the acked port, held between acks
//   mem_en     out  memory access strobe
//   mem_be     out  4 byte write enables (0000 for reads)
//   mem_idx    out  ADDR_W-2 word index
//   mem_wdata  out  32 lane-placed write data
//   mem_rdata  in   32 memory read data, valid the cycle after mem_en
// ============================================================================
module dm_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_idx,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_WORD = 2'd1;
    localparam logic [1:0] TYPE_BYTE = 2'd2;
    localparam logic [1:0] TYPE_HALF = 2'd3;

    state_t              state_r;
    logic                port_dma_r;   // latched winner: 1 = DMA
    logic                we_r;         // latched direction of the access
    logic [31:0]         rdata_r;
    logic                cpu_ack_r;
    logic                dma_ack_r;
    logic                mem_en_r;
    logic [3:0]          mem_be_r;
    logic [ADDR_W-3:0]   mem_idx_r;
    logic [31:0]         mem_wdata_r;
`ifdef DM_ARB_RR_EN
    logic                last_dma_r;   // last grant went to DMA
`endif

    logic                arb_ok_s;
    logic                gnt_cpu_s;
    logic                gnt_dma_s;
    logic                sel_we_s;
    logic [1:0]          sel_type_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;

    // Byte enables for one access; reads and illegal types enable no lanes.
    function automatic logic [3:0] lane_be(input logic we,
                                           input logic [1:0] typ,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        if (we) begin
            case (typ)
                TYPE_WORD: be = 4'b1111;
                TYPE_BYTE: be = 4'b0001 << off;
                TYPE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
                default:   be = 4'b0000;
            endcase
        end else begin
            be = 4'b0000;
        end
        return be;
    endfunction

    // Replicate the right-aligned write data into every lane it may target.
    function automatic logic [31:0] lane_data(input logic we,
                                              input logic [1:0] typ,
                                              input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0000_0000;
        if (we) begin
            case (typ)
                TYPE_WORD: d = wd;
                TYPE_BYTE: d = {4{wd[7:0]}};
                TYPE_HALF: d = {2{wd[15:0]}};
                default:   d = 32'h0000_0000;
            endcase
        end else begin
            d = 32'h0000_0000;
        end
        return d;
    endfunction

    // Arbitration: grants only in IDLE/RESP, never while reset is held.
    always_comb begin
        arb_ok_s  = reset && ((state_r == ST_IDLE) || (state_r == ST_RESP));
        gnt_cpu_s = 1'b0;
        gnt_dma_s = 1'b0;
        if (arb_ok_s) begin
            if (cpu_req && dma_req) begin
`ifdef DM_ARB_RR_EN
                if (last_dma_r) begin
                    gnt_cpu_s = 1'b1;
                end else begin
                    gnt_dma_s = 1'b1;
                end
`else
                gnt_cpu_s = 1'b1;
`endif
            end else if (cpu_req) begin
                gnt_cpu_s = 1'b1;
            end else if (dma_req) begin
                gnt_dma_s = 1'b1;
            end else begin
                gnt_cpu_s = 1'b0;
                gnt_dma_s = 1'b0;
            end
        end else begin
            gnt_cpu_s = 1'b0;
            gnt_dma_s = 1'b0;
        end
    end

    // Request fields of the winner; the DMA port is always word-sized.
    always_comb begin
        if (gnt_dma_s) begin
            sel_we_s    = dma_we;
            sel_type_s  = TYPE_WORD;
            sel_addr_s  = dma_addr;
            sel_wdata_s = dma_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_type_s  = cpu_type;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Sequencer: state, latched request, memory strobes and acknowledges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            port_dma_r  <= 1'b0;
            we_r        <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_idx_r   <= '0;
            mem_wdata_r <= 32'h0000_0000;
`ifdef DM_ARB_RR_EN
            last_dma_r  <= 1'b1;
`endif
        end else begin
            // mem_* and acks are single-cycle; only the grant path sets them.
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_idx_r   <= '0;
            mem_wdata_r <= 32'h0000_0000;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if ((state_r == ST_RESP) && !we_r) begin
                        rdata_r <= mem_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    if (gnt_cpu_s || gnt_dma_s) begin
                        port_dma_r  <= gnt_dma_s;
                        we_r        <= sel_we_s;
                        mem_en_r    <= 1'b1;
                        mem_be_r    <= lane_be(sel_we_s, sel_type_s, sel_addr_s[1:0]);
                        mem_idx_r   <= sel_addr_s[ADDR_W-1:2];
                        mem_wdata_r <= lane_data(sel_we_s, sel_type_s, sel_wdata_s);
`ifdef DM_ARB_RR_EN
                        last_dma_r  <= gnt_dma_s;
`endif
                        state_r     <= ST_ACCESS;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    cpu_ack_r <= !port_dma_r;
                    dma_ack_r <= port_dma_r;
                    state_r   <= ST_RESP;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_gnt   = gnt_cpu_s;
    assign dma_gnt   = gnt_dma_s;
    assign cpu_ack   = cpu_ack_r;
    assign dma_ack   = dma_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_be    = mem_be_r;
    assign mem_idx   = mem_idx_r;
    assign mem_wdata = mem_wdata_r;
    // Memory data arrives in the ack cycle itself, so a read ack forwards it
    // directly; the captured copy holds it until the next read ack.
    assign rdata     = ((state_r == ST_RESP) && !we_r) ? mem_rdata : rdata_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// tb_dm_arbiter
// ----------------------------------------------------------------------------
// Directed bench for dm_arbiter (default build, fixed CPU priority). A small
// byte-enabled synchronous RAM model sits on the memory port.
// ============================================================================
module tb_dm_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [1:0]        cpu_type;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt, cpu_ack;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_gnt, dma_ack;
    logic [31:0]       rdata;
    logic              mem_en;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_idx;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0]       ram [0:255] = '{default: 32'h0};

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_type(cpu_type),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_be(mem_be),
        .mem_idx(mem_idx), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM model: read-before-write, data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) ram[mem_idx[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_idx[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete CPU access, started in an IDLE cycle with no DMA request.
    task automatic cpu_txn(input logic we, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] exp_be, input logic chk_wd,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                           input string tag);
        cpu_req = 1'b1; cpu_we = we; cpu_type = typ; cpu_addr = addr; cpu_wdata = wd;
        #1;
        chk({tag, " cpu_gnt"}, cpu_gnt, 1);
        chk({tag, " dma_gnt"}, dma_gnt, 0);
        step();
        cpu_req = 1'b0;
        chk({tag, " mem_en"}, mem_en, 1);
        chk({tag, " mem_be"}, mem_be, exp_be);
        chk({tag, " mem_idx"}, mem_idx, addr[31:2]);
        if (chk_wd) chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
        chk({tag, " no ack in access"}, cpu_ack, 0);
        step();
        chk({tag, " cpu_ack"}, cpu_ack, 1);
        chk({tag, " mem_en off in resp"}, mem_en, 0);
        if (!we) chk({tag, " rdata"}, rdata, exp_rd);
        step();
        chk({tag, " ack single pulse"}, cpu_ack, 0);
    endtask

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_type = 2'd0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        #3;
        chk("rst cpu_gnt", cpu_gnt, 0);
        chk("rst dma_gnt", dma_gnt, 0);
        chk("rst cpu_ack", cpu_ack, 0);
        chk("rst dma_ack", dma_ack, 0);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_be", mem_be, 0);
        chk("rst mem_idx", mem_idx, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rdata", rdata, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // Word write then read back; byte/half lanes; illegal type.
        cpu_txn(1'b1, 2'd1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0, "wr word");
        cpu_txn(1'b0, 2'd1, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 32'hDEADBEEF, "rd word");
        cpu_txn(1'b1, 2'd2, 32'h13, 32'h000000AB, 4'b1000, 1'b1, 32'hABABABAB, 32'h0, "wr byte3");
        cpu_txn(1'b1, 2'd3, 32'h12, 32'h00001234, 4'b1100, 1'b1, 32'h12341234, 32'h0, "wr half hi");
        cpu_txn(1'b0, 2'd1, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h1234BEEF, "rd after lanes");
        cpu_txn(1'b1, 2'd3, 32'h10, 32'h00005678, 4'b0011, 1'b1, 32'h56785678, 32'h0, "wr half lo");
        cpu_txn(1'b1, 2'd2, 32'h11, 32'h000000CD, 4'b0010, 1'b1, 32'hCDCDCDCD, 32'h0, "wr byte1");
        cpu_txn(1'b1, 2'd3, 32'h10, 32'h00005678, 4'b0011, 1'b1, 32'h56785678, 32'h0, "restore half");
        cpu_txn(1'b1, 2'd0, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 32'h0, "wr illegal");
        cpu_txn(1'b0, 2'd1, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h12345678, "rd after illegal");

        // DMA write with unaligned address still writes the full word.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h23; dma_wdata = 32'hCAFEF00D;
        #1;
        chk("dma wr dma_gnt", dma_gnt, 1);
        chk("dma wr cpu_gnt", cpu_gnt, 0);
        step();
        dma_req = 1'b0;
        chk("dma wr mem_be", mem_be, 4'b1111);
        chk("dma wr mem_idx", mem_idx, 8);
        chk("dma wr mem_wdata", mem_wdata, 32'hCAFEF00D);
        step();
        chk("dma wr dma_ack", dma_ack, 1);
        chk("dma wr cpu_ack", cpu_ack, 0);
        step();

        // Tie, back-to-back: CPU keeps winning while it requests.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_type = 2'd1; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        #1;
        chk("tie1 cpu_gnt", cpu_gnt, 1);
        chk("tie1 dma_gnt", dma_gnt, 0);
        step();
        chk("tie access cpu_gnt", cpu_gnt, 0);
        chk("tie access dma_gnt", dma_gnt, 0);
        chk("tie access mem_en", mem_en, 1);
        step();
        chk("tie resp cpu_ack", cpu_ack, 1);
        chk("tie resp rdata", rdata, 32'h12345678);
        chk("tie2 cpu_gnt", cpu_gnt, 1);
        chk("tie2 dma_gnt", dma_gnt, 0);
        step();
        cpu_req = 1'b0;
        chk("tie2 mem_en", mem_en, 1);
        chk("tie2 mem_idx", mem_idx, 4);
        step();
        chk("tie2 cpu_ack", cpu_ack, 1);
        chk("dma after cpu dma_gnt", dma_gnt, 1);
        chk("dma after cpu cpu_gnt", cpu_gnt, 0);
        step();
        dma_req = 1'b0;
        chk("dma rd mem_idx", mem_idx, 8);
        chk("dma rd mem_be", mem_be, 4'b0000);
        step();
        chk("dma rd dma_ack", dma_ack, 1);
        chk("dma rd rdata", rdata, 32'hCAFEF00D);
        step();
        chk("dma rd ack pulse", dma_ack, 0);
        chk("rdata held", rdata, 32'hCAFEF00D);

        // Reset pulled low in the RESP cycle of a DMA read.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        #1;
        chk("rstresp dma_gnt", dma_gnt, 1);
        step();
        dma_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("rstresp dma_ack", dma_ack, 0);
        chk("rstresp rdata", rdata, 0);
        chk("rstresp mem_en", mem_en, 0);
        chk("rstresp mem_be", mem_be, 0);
        chk("rstresp mem_wdata", mem_wdata, 0);
        step();
        chk("rstresp dma_ack later", dma_ack, 0);
        reset = 1'b1;
        cpu_txn(1'b0, 2'd1, 32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h12345678, "after reset");

        // DMA request withdrawn while the CPU holds the grant.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_type = 2'd1; cpu_addr = 32'h30; cpu_wdata = 32'h11112222;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h99999999;
        #1;
        chk("wd cpu_gnt", cpu_gnt, 1);
        chk("wd dma_gnt", dma_gnt, 0);
        step();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("wd access dma_gnt", dma_gnt, 0);
        chk("wd mem_idx", mem_idx, 12);
        step();
        chk("wd resp cpu_ack", cpu_ack, 1);
        chk("wd resp dma_gnt", dma_gnt, 0);
        step();
        chk("wd idle mem_en", mem_en, 0);
        chk("wd idle dma_gnt", dma_gnt, 0);
        step();
        chk("wd no access", mem_en, 0);
        chk("wd no dma_ack", dma_ack, 0);
        chk("wd ram untouched", ram[16], 32'h0);
        chk("wd cpu word", ram[12], 32'h11112222);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
